seq_pattern_detect_ctrl: RTL and testbench
==========================================

// Module: seq_pattern_detect_ctrl
// PURPOSE
//  Controller/sequencer for the serial sequence-detection datapath. Loads a runtime pattern
//  (1..MAX_LEN bits) over a valid/ready config port, arms on start and consumes a
//  valid/ready serial bit stream. Emits a Mealy match pulse per hit, counts hits and
//  stops in DONE at a programmed threshold. Sits between the stream source and the
//  system's interrupt/status logic.
// PARAMETERS
//  MAX_LEN  8  max pattern length in bits (>=2); LEN_W = $clog2(MAX_LEN+1) derived localparam
//  CNT_W    8  width of match counter and threshold
// PORTS
//  clk          in   1          clock, rising edge
//  reset_n      in   1          reset, asynchronous, active-low
//  cfg_valid    in   1          config request
//  cfg_ready    out  1          config accepted when cfg_valid&&cfg_ready
//  cfg_pattern  in   MAX_LEN    pattern; bit [len-1] = first bit received, bit [0] = last
//  cfg_len      in   LEN_W      pattern length, legal 1..MAX_LEN
//  cfg_thresh   in   CNT_W      match count that ends the run; 0 = never end (count only)
//  cfg_err      out  1          1-cycle pulse: illegal cfg_len handshaken, config not loaded
//  start        in   1          arm detection (IDLE only, needs loaded config)
//  stop         in   1          abort RUN or leave DONE -> IDLE
//  bit_valid    in   1          serial bit present
//  bit_ready    out  1          bit consumed when bit_valid&&bit_ready
//  bit_in       in   1          serial data bit
//  match        out  1          combinational Mealy pulse, same cycle as the completing bit
//  match_cnt    out  CNT_W      registered hit count, saturates at all-ones
//  busy         out  1          state==RUN
//  done         out  1          state==DONE (level)
// BEHAVIOUR
//  - Reset: state IDLE, cfg_loaded=0, history/fill/match_cnt=0; cfg_err=0, match=0,
//    busy=0, done=0, bit_ready=0; cfg_ready=1 (IDLE, combinational).
//  - FSM (enum, registered, async reset) IDLE/RUN/DONE; next-state+outputs in one always_comb.
//  - IDLE: cfg_ready=1. Handshake with 1<=cfg_len<=MAX_LEN latches pattern/len/thresh,
//    cfg_loaded=1. Otherwise cfg_err pulses next cycle and prior config is kept.
//    start&&cfg_loaded&&!stop -> RUN; clear history, fill counter, match_cnt.
//    start without loaded config: ignored. start&&stop: stay IDLE.
//  - RUN: bit_ready = !stop. Accepted bit shifts in LSB: hist <= {hist[MAX_LEN-2:0], bit_in}.
//    fill counter saturates at len.
//    match = accepted && (fill+1 >= len) && ({hist,bit_in}[len-1:0] == pattern[len-1:0]).
//    match_cnt <= match_cnt+1 on match (saturating). thresh!=0 && match && cnt+1==thresh
//    -> DONE next cycle, final match pulse still asserted. stop -> IDLE; bit not consumed
//    that cycle; match_cnt held for readout. start and cfg_valid ignored.
//  - DONE: bit_ready=0, match=0, done=1; match_cnt held. stop -> IDLE; start ignored.
//  - Leaving IDLE does not clear cfg_loaded; re-start reuses config. reset_n low mid-RUN
//    returns everything to reset values within the same cycle (async).
//  - Bit-level latency: 0 cycles input-to-match; 1 cycle to match_cnt/done update.
// CONFIGURATION
//  SEQ_PATTERN_DETECT_CTRL_OVERLAP_EN
//   defined  : history retained after a match; overlapping hits count (101 in 10101 -> 2).
//   undefined: history and fill cleared in the cycle after a match; next hit must use only
//              new bits (101 in 10101 -> 1).
// TESTING
//  T1 reset: assert reset_n=0 mid-RUN -> IDLE, match_cnt=0, busy=0, cfg_ready=1 same cycle.
//  T2 cfg pattern=3'b101 len=3 thresh=0, start, stream 1,0,1,0,1 -> OVERLAP_EN: match at bits 3,5,
//     match_cnt=2; undefined: match at bit 3 only, match_cnt=1.
//  T3 pattern=2'b11 len=2 thresh=3, stream 1,1,1,1 -> (OVERLAP_EN) match bits 2,3,4; DONE after bit 4,
//     bit_ready=0, done=1, match_cnt=3; stop -> IDLE.
//  T4 cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulse each, cfg_loaded stays 0, start ignored.
//  T5 RUN, bit_valid=1 and stop=1 same cycle -> bit_ready=0, no match, IDLE next, match_cnt held.
//  T6 bit_valid gaps (random 0..3 idle cycles) with pattern 8'b1011_0010 len=8 -> single match,
//     identical result to gapless stream.

Source files
------------

// File: rtl/seq_pattern_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_detect_ctrl
// Purpose  : Controller/sequencer for the serial sequence-detection datapath.
//            A runtime pattern (1..MAX_LEN bits) is loaded over a valid/ready
//            config port. On start the block consumes a valid/ready serial
//            bit stream. It raises a Mealy match pulse for each hit, counts
//            hits and parks in DONE once a programmed threshold is reached.
// Ports    : clk, reset_n (async, active-low)
//            cfg_valid/cfg_ready, cfg_pattern, cfg_len, cfg_thresh, cfg_err
//            start, stop
//            bit_valid/bit_ready, bit_in
//            match (combinational), match_cnt, busy, done
// Config   : SEQ_PATTERN_DETECT_CTRL_OVERLAP_EN
//            defined   -> history is kept after a hit, so overlapping hits count
//            undefined -> history is cleared after a hit, so hits never overlap
// Revision : 1.0  initial release
// ============================================================================
module seq_pattern_detect_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               bit_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

`ifdef SEQ_PATTERN_DETECT_CTRL_OVERLAP_EN
  localparam bit c_overlap = 1'b1;
`else
  localparam bit c_overlap = 1'b0;
`endif

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_loaded;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_thr;
  // Only MAX_LEN-1 past bits are ever needed: the newest bit comes from bit_in.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;

  logic               w_len_ok;
  logic               w_cfg_take;
  logic               w_arm;
  logic               w_accept;
  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_p1;
  logic               w_full;
  logic [CNT_W:0]     w_cnt_p1;

  assign w_len_ok  = (cfg_len != '0) && (cfg_len <= c_max_len);
  // Window of the last MAX_LEN bits including the one being offered now;
  // bit [0] is the newest, which lines up with pattern bit [0].
  assign w_win     = {r_hist, bit_in};
  assign w_fill_p1 = {1'b0, r_fill} + 1'b1;
  assign w_full    = (w_fill_p1 >= {1'b0, r_len});
  assign w_cnt_p1  = {1'b0, r_cnt} + 1'b1;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    bit_ready   = 1'b0;
    match       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_cfg_take  = 1'b0;
    w_arm       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready  = 1'b1;
        w_cfg_take = cfg_valid;
        if (start && r_loaded && !stop) begin
          w_state_nxt = ST_RUN;
          w_arm       = 1'b1;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        bit_ready = !stop;
        w_accept  = bit_valid && !stop;
        match     = w_accept && w_full && (((w_win ^ r_pat) & w_mask) == '0);
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (match && (r_thr != '0) && (w_cnt_p1 == {1'b0, r_thr})) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Config registers: an illegal length leaves the previous config intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded  <= 1'b0;
      r_pat     <= '0;
      r_len     <= '0;
      r_thr     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (w_cfg_take) begin
        if (w_len_ok) begin
          r_loaded <= 1'b1;
          r_pat    <= cfg_pattern;
          r_len    <= cfg_len;
          r_thr    <= cfg_thresh;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (w_arm) begin
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      if (match && !c_overlap) begin
        // Non-overlapping mode: the next hit must be built from fresh bits.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_win[MAX_LEN-2:0];
        r_fill <= w_full ? r_len : w_fill_p1[LEN_W-1:0];
      end
      if (match && (r_cnt != c_cnt_max)) begin
        r_cnt <= w_cnt_p1[CNT_W-1:0];
      end
    end
  end

  assign cfg_err   = r_cfg_err;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_detect_ctrl
// Purpose  : Self-checking bench for seq_pattern_detect_ctrl. A behavioural
//            model keeps the accepted bit stream in a queue and looks for the
//            pattern at its tail; the DUT is compared with it every cycle.
//            Directed scenarios are followed by a randomized run.
// Config   : honours SEQ_PATTERN_DETECT_CTRL_OVERLAP_EN like the design
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_pattern_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

`ifdef SEQ_PATTERN_DETECT_CTRL_OVERLAP_EN
  localparam bit c_overlap = 1'b1;
`else
  localparam bit c_overlap = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               bit_valid;
  logic               bit_ready;
  logic               bit_in;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;

  seq_pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_in(bit_in),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model state: 0 idle, 1 running, 2 finished.
  int  m_state;
  bit  m_loaded;
  bit  [MAX_LEN-1:0] m_pat;
  int  m_len;
  int  m_thr;
  int  m_cnt;
  bit  m_err;
  bit  q[$];

  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Does the stream in q followed by bit b end with the programmed pattern?
  function automatic bit model_hit(input bit b);
    if (q.size() + 1 < m_len) return 1'b0;
    if (m_pat[0] != b) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (q[q.size() - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_loaded = 1'b0;
    m_pat    = '0;
    m_len    = 0;
    m_thr    = 0;
    m_cnt    = 0;
    m_err    = 1'b0;
    q.delete();
  endtask

  // One clock: compare settled outputs on the falling edge, advance the model,
  // then return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    bit rdy, acc, hit, err_nxt, old_loaded;
    int old_cnt;
    @(negedge clk);
    rdy = (m_state == 1) && !stop;
    acc = rdy && bit_valid;
    hit = acc && model_hit(bit_in);
    check("cfg_ready", 32'(cfg_ready), 32'(m_state == 0));
    check("busy",      32'(busy),      32'(m_state == 1));
    check("done",      32'(done),      32'(m_state == 2));
    check("bit_ready", 32'(bit_ready), 32'(rdy));
    check("match",     32'(match),     32'(hit));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    check("cfg_err",   32'(cfg_err),   32'(m_err));

    err_nxt    = 1'b0;
    old_loaded = m_loaded;
    old_cnt    = m_cnt;
    case (m_state)
      0: begin
        if (cfg_valid) begin
          if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
            m_loaded = 1'b1;
            m_pat    = cfg_pattern;
            m_len    = int'(cfg_len);
            m_thr    = int'(cfg_thresh);
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (start && old_loaded && !stop) begin
          m_state = 1;
          m_cnt   = 0;
          q.delete();
        end
      end
      1: begin
        if (stop) begin
          m_state = 0;
        end else if (acc) begin
          if (hit) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_thr != 0 && old_cnt + 1 == m_thr) m_state = 2;
          end
          if (hit && !c_overlap) begin
            q.delete();
          end else begin
            q.push_back(bit_in);
            if (q.size() > MAX_LEN) void'(q.pop_front());
          end
        end
      end
      default: begin
        if (stop) m_state = 0;
      end
    endcase
    m_err = err_nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_thresh  = '0;
    start       = 1'b0;
    stop        = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int len, input int thr);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(len);
    cfg_thresh  = CNT_W'(thr);
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic feed(input bit b, input int gaps);
    bit_valid = 1'b0;
    for (int g = 0; g < gaps; g++) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_match",     32'(match),     32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [MAX_LEN-1:0] t6_pat;

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    #1;
    check("por_cfg_ready", 32'(cfg_ready), 32'd1);
    check("por_busy",      32'(busy),      32'd0);
    check("por_match_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a run.
    do_cfg(3'b101, 3, 0);
    do_start();
    feed(1, 0); feed(0, 0); feed(1, 0);
    check("t1_pre_cnt", 32'(match_cnt), 32'd1);
    bit_valid = 1'b1; bit_in = 1'b1;
    async_reset();
    bit_valid = 1'b0;

    // 101 over 10101.
    do_cfg(3'b101, 3, 0);
    do_start();
    feed(1, 0); feed(0, 0); feed(1, 0); feed(0, 0); feed(1, 0);
    check("t2_cnt", 32'(match_cnt), c_overlap ? 32'd2 : 32'd1);
    do_stop();

    // 11 with threshold 3 over 1111.
    do_cfg(2'b11, 2, 3);
    do_start();
    feed(1, 0); feed(1, 0); feed(1, 0); feed(1, 0);
    check("t3_cnt",  32'(match_cnt), c_overlap ? 32'd3 : 32'd2);
    check("t3_done", 32'(done),      c_overlap ? 32'd1 : 32'd0);
    check("t3_rdy",  32'(bit_ready), c_overlap ? 32'd0 : 32'd1);
    do_stop();
    check("t3_idle", 32'(cfg_ready), 32'd1);

    // Illegal lengths with no config loaded.
    async_reset();
    do_cfg(8'hA5, 0, 0);
    check("t4_err0", 32'(cfg_err), 32'd1);
    do_cfg(8'hA5, MAX_LEN + 1, 0);
    check("t4_err9", 32'(cfg_err), 32'd1);
    do_start();
    check("t4_nostart", 32'(busy), 32'd0);

    // Stop colliding with a valid bit.
    do_cfg(2'b11, 2, 0);
    do_start();
    feed(1, 0); feed(1, 0);
    bit_valid = 1'b1; bit_in = 1'b1; stop = 1'b1;
    tick();
    bit_valid = 1'b0; stop = 1'b0;
    check("t5_idle", 32'(busy),      32'd0);
    check("t5_cnt",  32'(match_cnt), 32'd1);

    // Full-length pattern, gapless then with random gaps.
    t6_pat = 8'b1011_0010;
    do_cfg(t6_pat, 8, 0);
    for (int pass = 0; pass < 2; pass++) begin
      do_start();
      for (int i = MAX_LEN - 1; i >= 0; i--) begin
        feed(t6_pat[i], (pass == 0) ? 0 : int'($urandom_range(0, 3)));
      end
      check("t6_cnt", 32'(match_cnt), 32'd1);
      do_stop();
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_len     = LEN_W'($urandom_range(0, MAX_LEN + 1));
      cfg_pattern = MAX_LEN'($urandom);
      cfg_thresh  = CNT_W'($urandom_range(0, 4));
      start       = ($urandom_range(0, 4) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      bit_valid   = ($urandom_range(0, 9) < 7);
      bit_in      = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
